// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional feature macro: DIV_FAST_SPECIAL_EN (divide-by-zero/overflow resolved at accept)
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [1:0]      funct,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      CNT_INIT = 6'(XLEN-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            signed_op, op1_neg, op2_neg, div_zero, div_ovf, r_ge;
  logic [XLEN-1:0] op1_mag, op2_mag, spec_res, q_fix, r_fix;
  logic [XLEN:0]   r_sh;

  // Operand decode: magnitudes are unsigned, so |MIN_NEG| stays MIN_NEG.
  assign signed_op = ~funct[0];
  assign op1_neg   = signed_op & op1[XLEN-1];
  assign op2_neg   = signed_op & op2[XLEN-1];
  assign op1_mag   = op1_neg ? -op1 : op1;
  assign op2_mag   = op2_neg ? -op2 : op2;
  assign div_zero  = (op2 == '0);
  assign div_ovf   = signed_op && (op1 == MIN_NEG) && (op2 == '1);
  assign spec_res  = div_zero ? (funct[1] ? op1 : '1) : (funct[1] ? '0 : MIN_NEG);

  assign r_sh  = {r_q, q_q[XLEN-1]};
  assign r_ge  = (r_sh >= {1'b0, dvs_q});
  assign q_fix = qneg_q ? -q_q : q_q;
  assign r_fix = rneg_q ? -r_q : r_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    dvs_d      = dvs_q;
    is_rem_d   = is_rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    res_d      = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d   = funct[1];
          qneg_d     = op1_neg ^ op2_neg;
          rneg_d     = op1_neg;
          special_d  = div_zero | div_ovf;
          spec_res_d = spec_res;
          q_d        = op1_mag;
          r_d        = '0;
          dvs_d      = op2_mag;
          cnt_d      = CNT_INIT;
          state_d    = S_RUN;
`ifdef DIV_FAST_SPECIAL_EN
          if (div_zero || div_ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        // Only the low XLEN bits survive: a successful subtraction leaves R < divisor.
        if (r_ge) begin
          r_d = r_sh[XLEN-1:0] - dvs_q;
          q_d = {q_q[XLEN-2:0], 1'b1};
        end else begin
          r_d = r_sh[XLEN-1:0];
          q_d = {q_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = special_q ? spec_res_q : (is_rem_q ? r_fix : q_fix);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dvs_q      <= '0;
      is_rem_q   <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dvs_q      <= dvs_d;
      is_rem_q   <= is_rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule
